riscv_lsu_split: RTL and testbench
==================================

RISCV_LSU_SPLIT -- requirements
Module: riscv_lsu_split

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of core and memory addresses.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, meaning wait cycles per memory access before a bus error (minimum 1).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have core ports:
- core_req_i, input, 1
- core_we_i, input, 1
- core_size_i, input, 3 (LDST_* encoding)
- core_addr_i, input, ADDR_W
- core_wd_i, input, 32
- core_rd_o, output, 32
- core_stall_o, output, 1
- core_err_o, output, 1 (bus error or misalign fault)
REQ-006 SHALL have memory ports:
- mem_rd_i, input, 32
- mem_ready_i, input, 1
- mem_req_o, output, 1
- mem_we_o, output, 1
- mem_be_o, output, 4
- mem_addr_o, output, ADDR_W (always word-aligned)
- mem_wd_o, output, 32

Function
REQ-007 SHALL implement the FSM IDLE, LO, HI, RESP; mem_req_o is 1 only in LO and HI.
REQ-008 SHALL require the core to hold core_req_i and all core_* inputs stable while core_stall_o=1.
REQ-009 SHALL drive core_stall_o = core_req_i & (state != RESP).
REQ-010 SHALL transition IDLE->LO when core_req_i=1, latching we, size, address and write data; the latched values drive the memory side.
REQ-011 SHALL treat an access as split when offset = addr[1:0] and size violate natural alignment:
- word: offset != 0
- half/halfu: offset = 3
- byte: never split
REQ-012 SHALL in LO drive mem_addr_o = addr & ~3, mem_be_o = (size mask << offset)[3:0], and mem_wd_o = low 32 bits of ({32'b0, wd} << 8*offset).
REQ-013 SHALL in HI drive mem_addr_o = (addr & ~3) + 4 modulo 2^ADDR_W, mem_be_o = (size mask << offset)[7:4], and mem_wd_o = bits 63:32 of the same shift.
REQ-014 SHALL on mem_ready_i=1 in LO capture mem_rd_i as rd_lo and go to HI if split, else RESP; on mem_ready_i=1 in HI capture rd_hi and go to RESP.
REQ-015 SHALL form load data as ({rd_hi, rd_lo} >> 8*offset), truncated to the access size; sign-extend for B/H, zero-extend for BU/HU.
REQ-016 SHALL register core_rd_o and hold it valid in RESP; the value is undefined elsewhere. Stores SHALL return core_rd_o = 0.
REQ-017 SHALL go RESP->IDLE unconditionally; a core_req_i held high in RESP starts no new access until IDLE.
REQ-018 SHALL give latency from request (IDLE) to stall release: 3 cycles aligned and 4 cycles split, with zero-wait memory.
REQ-019 SHALL count consecutive cycles with mem_ready_i=0 in LO/HI (counter reset on each ready). On reaching TIMEOUT_CYC it SHALL go to RESP with core_err_o=1 and core_rd_o=0, abandoning any remaining half of a split.
REQ-020 SHALL assert core_err_o only in RESP; an error in LO skips HI.
REQ-021 SHALL treat core_size_i values outside LDST_* as LDST_W.

Reset
REQ-022 SHALL on rst_ni=0, regardless of state including mid-access, set state=IDLE, counter=0, rd_lo=rd_hi=0, and all outputs to 0 except core_stall_o, which follows core_req_i.
REQ-023 SHALL abandon a split access interrupted by reset without issuing its HI half.

Configuration
REQ-024 SHALL compile split support only when macro LSU_MISALIGN_SPLIT_EN is defined.
REQ-025 SHALL without LSU_MISALIGN_SPLIT_EN go IDLE->RESP for a misaligned request, with core_err_o=1, core_rd_o=0 and no memory access (latency 2); aligned behaviour is unchanged.

Structure
REQ-026 SHALL take LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5 and the lsu_state_t enum from riscv_pkg.
REQ-027 SHALL place byte-enable/write-data shifting and load extraction in the combinational sub-module riscv_lsu_align.

Verification
REQ-028 SHALL verify: lw at 0x100, ready immediate, mem_rd_i=0xDEADBEEF -> one access, be=1111, stall high 2 cycles, core_rd_o=0xDEADBEEF.
REQ-029 SHALL verify: lh at 0x203, first word 0x80xxxxxx, second word 0xxxxxxx12 -> accesses at 0x200 be=1000 and 0x204 be=0001, core_rd_o=0x00001280.
REQ-030 SHALL verify: sw 0xAABBCCDD at 0x301 -> 0x300 be=1110 wd=0xBBCCDDxx, then 0x304 be=0001 wd=0xxxxxxxAA.
REQ-031 SHALL verify: lw at 0xFFFFFFFE (ADDR_W=32) -> second access address 0x00000000, be=0011.
REQ-032 SHALL verify: mem_ready_i held 0 with TIMEOUT_CYC=4 -> core_err_o=1 after 4 wait cycles, no HI access, core_rd_o=0.
REQ-033 SHALL verify: rst_ni pulsed low in HI -> mem_req_o=0 immediately, state IDLE; without the macro, lw at 0x2 -> core_err_o=1 and no mem_req_o.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared load/store size encodings, LSU FSM states and size helpers.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Unknown size codes behave as a full word.
  function automatic logic [2:0] ldst_norm(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_BU, LDST_HU: return size;
      default:                          return LDST_W;
    endcase
  endfunction

  function automatic logic [3:0] ldst_mask(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: return 4'b0001;
      LDST_H, LDST_HU: return 4'b0011;
      default:         return 4'b1111;
    endcase
  endfunction

  function automatic logic ldst_split(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: return 1'b0;
      LDST_H, LDST_HU: return off == 2'd3;
      default:         return off != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane alignment: byte enables and write data for both halves of an
// access, plus load extraction and sign/zero extension.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_lo_i,
  input  logic [31:0] rd_hi_i,
  output logic [3:0]  be_lo_o,
  output logic [3:0]  be_hi_o,
  output logic [31:0] wd_lo_o,
  output logic [31:0] wd_hi_o,
  output logic [31:0] ld_o
);

  logic [4:0]  sh;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] ld_raw;

  always_comb begin
    sh      = {off_i, 3'b000};
    be_wide = {4'b0000, ldst_mask(size_i)} << off_i;
    wd_wide = {32'h0, wd_i} << sh;
    ld_raw  = 32'({rd_hi_i, rd_lo_i} >> sh);
    be_lo_o = be_wide[3:0];
    be_hi_o = be_wide[7:4];
    wd_lo_o = wd_wide[31:0];
    wd_hi_o = wd_wide[63:32];
    case (size_i)
      LDST_B:  ld_o = {{24{ld_raw[7]}}, ld_raw[7:0]};
      LDST_BU: ld_o = {24'h0, ld_raw[7:0]};
      LDST_H:  ld_o = {{16{ld_raw[15]}}, ld_raw[15:0]};
      LDST_HU: ld_o = {16'h0, ld_raw[15:0]};
      default: ld_o = ld_raw;
    endcase
  end

endmodule

// File: rtl/riscv_lsu_split.sv
// Load/store unit that splits misaligned accesses into two word accesses.
// Split support is built only with LSU_MISALIGN_SPLIT_EN; otherwise misaligned requests fault.
module riscv_lsu_split
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  input  logic [31:0]       mem_rd_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wd_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_lo_q, rd_lo_d;
  logic [31:0]       rd_hi_q, rd_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rd_q, rd_d;

  logic              split, misalign_fault, timeout;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        be_lo, be_hi;
  logic [31:0]       wd_lo, wd_hi, ld_data, rd_lo_sel, rd_hi_sel;

`ifdef LSU_MISALIGN_SPLIT_EN
  assign split          = ldst_split(size_q, addr_q[1:0]);
  assign misalign_fault = 1'b0;
`else
  assign split          = 1'b0;
  assign misalign_fault = ldst_split(ldst_norm(core_size_i), core_addr_i[1:0]);
`endif

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Bypass the word arriving this cycle so core_rd_o is ready on entry to RESP.
  assign rd_lo_sel = (state_q == LO) ? mem_rd_i : rd_lo_q;
  assign rd_hi_sel = (state_q == HI) ? mem_rd_i : rd_hi_q;

  riscv_lsu_align u_align (
    .size_i  (size_q),
    .off_i   (addr_q[1:0]),
    .wd_i    (wd_q),
    .rd_lo_i (rd_lo_sel),
    .rd_hi_i (rd_hi_sel),
    .be_lo_o (be_lo),
    .be_hi_o (be_hi),
    .wd_lo_o (wd_lo),
    .wd_hi_o (wd_hi),
    .ld_o    (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (core_req_i) begin
          we_d   = core_we_i;
          size_d = ldst_norm(core_size_i);
          addr_d = core_addr_i;
          wd_d   = core_wd_i;
          if (misalign_fault) begin
            state_d = RESP;
            err_d   = 1'b1;
            rd_d    = '0;
          end else begin
            state_d = LO;
          end
        end
      end
      LO, HI: begin
        if (mem_ready_i) begin
          cnt_d = '0;
          if (state_q == LO) rd_lo_d = mem_rd_i;
          else               rd_hi_d = mem_rd_i;
          if (state_q == LO && split) begin
            state_d = HI;
          end else begin
            state_d = RESP;
            rd_d    = we_q ? '0 : ld_data;
          end
        end else if (timeout) begin
          state_d = RESP;
          err_d   = 1'b1;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    case (state_q)
      LO: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = be_lo;
        mem_addr_o = word_addr;
        mem_wd_o   = wd_lo;
      end
      HI: begin
        mem_req_o  = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = be_hi;
        mem_addr_o = word_addr + ADDR_W'(4);
        mem_wd_o   = wd_hi;
      end
      default: ;
    endcase
    core_stall_o = core_req_i & (state_q != RESP);
    core_err_o   = err_q;
    core_rd_o    = rd_q;
  end

endmodule

// File: tb/tb_riscv_lsu_split.sv
// Directed bench for riscv_lsu_split; split-specific cases follow LSU_MISALIGN_SPLIT_EN.
module tb_riscv_lsu_split;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_size = LDST_W;
  logic [31:0] core_addr = '0, core_wd = '0;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_err_o;
  logic [31:0] mem_rd = '0;
  logic        mem_ready = 1'b1;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;

  riscv_lsu_split #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] acc_addr [8];
  logic [31:0] acc_wd   [8];
  logic [3:0]  acc_be   [8];
  logic        acc_we   [8];
  logic [31:0] rd_words [2];
  int          n_acc, n_stall;
  logic [31:0] resp_rd;
  logic        resp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic do_access(input string tag, input logic we, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    logic done;
    done = 1'b0; n_acc = 0; n_stall = 0; resp_rd = 'x; resp_err = 1'bx;
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_rd = rd_words[(n_acc < 2) ? n_acc : 1];
      #1;
      if (!core_stall_o) begin
        done = 1'b1;
        resp_rd = core_rd_o;
        resp_err = core_err_o;
      end else begin
        n_stall++;
        if (mem_req_o && n_acc < 8) begin
          acc_addr[n_acc] = mem_addr_o;
          acc_wd[n_acc]   = mem_wd_o;
          acc_be[n_acc]   = mem_be_o;
          acc_we[n_acc]   = mem_we_o;
          n_acc++;
        end
        @(negedge clk);
      end
    end
    check({tag, " completes"}, 32'(done), 32'd1);
    core_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_words[0] = '0; rd_words[1] = '0;
    // Reset state, stall follows core_req during reset.
    #12;
    check("rst mem_req", 32'(mem_req_o), 32'd0);
    check("rst err", 32'(core_err_o), 32'd0);
    check("rst rd", core_rd_o, 32'h0);
    check("rst be", 32'(mem_be_o), 32'h0);
    core_req = 1'b1; #1;
    check("rst stall follows req", 32'(core_stall_o), 32'd1);
    core_req = 1'b0; #1;
    check("rst stall low", 32'(core_stall_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Aligned lw.
    rd_words[0] = 32'hDEADBEEF;
    do_access("lw100", 1'b0, LDST_W, 32'h100, 32'h0);
    check("lw100 n_acc", 32'(n_acc), 32'd1);
    check("lw100 addr", acc_addr[0], 32'h100);
    check("lw100 be", 32'(acc_be[0]), 32'hF);
    check("lw100 stall", 32'(n_stall), 32'd2);
    check("lw100 rd", resp_rd, 32'hDEADBEEF);
    check("lw100 err", 32'(resp_err), 32'd0);

    // Byte/half loads within a word: extension rules.
    rd_words[0] = 32'h0000_8000;
    do_access("lb101", 1'b0, LDST_B, 32'h101, 32'h0);
    check("lb101 be", 32'(acc_be[0]), 32'h2);
    check("lb101 rd", resp_rd, 32'hFFFFFF80);
    do_access("lbu101", 1'b0, LDST_BU, 32'h101, 32'h0);
    check("lbu101 rd", resp_rd, 32'h00000080);
    rd_words[0] = 32'hF00D_1234;
    do_access("lh102", 1'b0, LDST_H, 32'h102, 32'h0);
    check("lh102 be", 32'(acc_be[0]), 32'hC);
    check("lh102 rd", resp_rd, 32'hFFFFF00D);
    do_access("lhu102", 1'b0, LDST_HU, 32'h102, 32'h0);
    check("lhu102 rd", resp_rd, 32'h0000F00D);
    // Undefined size code acts as a word.
    rd_words[0] = 32'h1234_5678;
    do_access("sz3", 1'b0, 3'd3, 32'h200, 32'h0);
    check("sz3 be", 32'(acc_be[0]), 32'hF);
    check("sz3 rd", resp_rd, 32'h12345678);

    // Aligned store returns zero read data.
    do_access("sb", 1'b1, LDST_B, 32'h503, 32'h0000_00A5);
    check("sb be", 32'(acc_be[0]), 32'h8);
    check("sb wd", acc_wd[0], 32'hA500_0000);
    check("sb we", 32'(acc_we[0]), 32'd1);
    check("sb rd", resp_rd, 32'h0);

    // Timeout on an aligned access.
    mem_ready = 1'b0;
    do_access("to", 1'b0, LDST_W, 32'h400, 32'h0);
    check("to req cycles", 32'(n_acc), 32'd4);
    check("to last addr", acc_addr[3], 32'h400);
    check("to stall", 32'(n_stall), 32'd5);
    check("to err", 32'(resp_err), 32'd1);
    check("to rd", resp_rd, 32'h0);
    mem_ready = 1'b1;

`ifdef LSU_MISALIGN_SPLIT_EN
    rd_words[0] = 32'h8011_2233; rd_words[1] = 32'h9988_7712;
    do_access("lh203", 1'b0, LDST_H, 32'h203, 32'h0);
    check("lh203 n_acc", 32'(n_acc), 32'd2);
    check("lh203 addr0", acc_addr[0], 32'h200);
    check("lh203 be0", 32'(acc_be[0]), 32'h8);
    check("lh203 addr1", acc_addr[1], 32'h204);
    check("lh203 be1", 32'(acc_be[1]), 32'h1);
    check("lh203 stall", 32'(n_stall), 32'd3);
    check("lh203 rd", resp_rd, 32'h00001280);

    do_access("sw301", 1'b1, LDST_W, 32'h301, 32'hAABBCCDD);
    check("sw301 n_acc", 32'(n_acc), 32'd2);
    check("sw301 addr0", acc_addr[0], 32'h300);
    check("sw301 be0", 32'(acc_be[0]), 32'hE);
    check("sw301 wd0", acc_wd[0] & 32'hFFFFFF00, 32'hBBCCDD00);
    check("sw301 we1", 32'(acc_we[1]), 32'd1);
    check("sw301 addr1", acc_addr[1], 32'h304);
    check("sw301 be1", 32'(acc_be[1]), 32'h1);
    check("sw301 wd1", acc_wd[1] & 32'h000000FF, 32'h000000AA);
    check("sw301 rd", resp_rd, 32'h0);

    rd_words[0] = 32'h5566_7788; rd_words[1] = 32'h1122_3344;
    do_access("lwwrap", 1'b0, LDST_W, 32'hFFFFFFFE, 32'h0);
    check("lwwrap addr0", acc_addr[0], 32'hFFFFFFFC);
    check("lwwrap be0", 32'(acc_be[0]), 32'hC);
    check("lwwrap addr1", acc_addr[1], 32'h00000000);
    check("lwwrap be1", 32'(acc_be[1]), 32'h3);
    check("lwwrap rd", resp_rd, 32'h33445566);

    // Timeout in LO of a split access: HI never issued.
    mem_ready = 1'b0;
    do_access("tosplit", 1'b0, LDST_W, 32'h401, 32'h0);
    check("tosplit req cycles", 32'(n_acc), 32'd4);
    check("tosplit last addr", acc_addr[3], 32'h400);
    check("tosplit err", 32'(resp_err), 32'd1);
    mem_ready = 1'b1;

    // Reset asserted during the HI half.
    core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h401;
    @(negedge clk); @(negedge clk); #1;
    check("rsthi in hi", mem_addr_o, 32'h404);
    rst_n = 1'b0; #1;
    check("rsthi mem_req", 32'(mem_req_o), 32'd0);
    check("rsthi stall", 32'(core_stall_o), 32'd1);
`else
    do_access("lw2", 1'b0, LDST_W, 32'h2, 32'h0);
    check("lw2 n_acc", 32'(n_acc), 32'd0);
    check("lw2 stall", 32'(n_stall), 32'd1);
    check("lw2 err", 32'(resp_err), 32'd1);
    check("lw2 rd", resp_rd, 32'h0);
    do_access("lh203", 1'b0, LDST_H, 32'h203, 32'h0);
    check("lh203 n_acc", 32'(n_acc), 32'd0);
    check("lh203 err", 32'(resp_err), 32'd1);
    do_access("lh201", 1'b0, LDST_H, 32'h201, 32'h0);
    check("lh201 n_acc", 32'(n_acc), 32'd1);
    check("lh201 be", 32'(acc_be[0]), 32'h6);

    // Reset asserted during LO.
    core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h100;
    mem_ready = 1'b0;
    @(negedge clk); #1;
    check("rstlo in lo", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0; #1;
    check("rstlo mem_req", 32'(mem_req_o), 32'd0);
    check("rstlo stall", 32'(core_stall_o), 32'd1);
    mem_ready = 1'b1;
`endif
    check("rst err mid", 32'(core_err_o), 32'd0);
    core_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("post rst idle", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    rd_words[0] = 32'hCAFEF00D;
    do_access("relw", 1'b0, LDST_W, 32'h100, 32'h0);
    check("relw n_acc", 32'(n_acc), 32'd1);
    check("relw stall", 32'(n_stall), 32'd2);
    check("relw rd", resp_rd, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
